// File: rtl/uart_prog_loader.sv
// Assembles a UART byte stream (16-bit word count, then little-endian words)
// into program ROM writes and holds the CPU in upgrade mode while loading.
module uart_prog_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 2300000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o,
  output logic              busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        n_lo;
  logic [15:0]       n_words;
  logic [15:0]       hdr_n;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       lanes;
  logic              last_wr;
  logic [TW-1:0]     tcnt;
  logic              timeout;
  logic              rst_d, busy_d, done_d, err_d;

  assign hdr_n   = {rx_byte, n_lo};
  assign timeout = (tcnt == TW'(TIMEOUT_CYC - 1)) && !rx_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_HDR0;
        else       state_nxt = state;
      end
      S_HDR0: begin
        if (rx_valid) state_nxt = S_HDR1;
        else          state_nxt = S_HDR0;
      end
      S_HDR1: begin
        if (rx_valid) begin
          if (hdr_n == 16'd0)                             state_nxt = S_DONE;
          else if (32'(hdr_n) > (32'd1 << ADDR_W))        state_nxt = S_ERR;
          else                                            state_nxt = S_DATA;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_HDR1;
        end
      end
      S_DATA: begin
        // last_wr marks the cycle in which the final word's strobe is visible
        if (last_wr)      state_nxt = S_DONE;
        else if (timeout) state_nxt = S_ERR;
        else              state_nxt = S_DATA;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state, registered below
  always_comb begin
    rst_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_nxt)
      S_IDLE:                 rst_d  = 1'b1;
      S_HDR0, S_HDR1, S_DATA: busy_d = 1'b1;
      S_DONE:                 done_d = 1'b1;
      S_ERR:                  err_d  = 1'b1;
      default:                rst_d  = 1'b1;
    endcase
  end

  // Datapath: header capture, word assembly, write strobe, timeout counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      upg_rst_o  <= 1'b1;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= 32'd0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
      busy_o     <= 1'b0;
      n_lo       <= 8'd0;
      n_words    <= 16'd0;
      word_idx   <= '0;
      byte_idx   <= 2'd0;
      lanes      <= 24'd0;
      last_wr    <= 1'b0;
      tcnt       <= '0;
    end else begin
      upg_rst_o  <= rst_d;
      upg_done_o <= done_d;
      upg_err_o  <= err_d;
      busy_o     <= busy_d;
      upg_wen_o  <= 1'b0;
      last_wr    <= 1'b0;

      if ((state == S_HDR1 || state == S_DATA) && state_nxt == state && !rx_valid)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;

      if (state == S_HDR0 && rx_valid) begin
        n_lo <= rx_byte;
      end else if (state == S_HDR1 && rx_valid) begin
        n_words  <= hdr_n;
        word_idx <= '0;
        byte_idx <= 2'd0;
      end else if (state == S_DATA && !last_wr && rx_valid) begin
        case (byte_idx)
          2'd0: lanes[7:0]   <= rx_byte;
          2'd1: lanes[15:8]  <= rx_byte;
          2'd2: lanes[23:16] <= rx_byte;
          default: begin
            upg_wen_o <= 1'b1;
            upg_adr_o <= word_idx[ADDR_W-1:0];
            upg_dat_o <= {rx_byte, lanes};
            word_idx  <= word_idx + (ADDR_W+1)'(1);
            last_wr   <= (32'(word_idx) + 32'd1) == 32'(n_words);
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
      end else begin
        n_lo <= n_lo;
      end
    end
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder for the instruction fetch stage's program ROM upgrade port.
- Receives a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word to the ROM through the upg_* interface, then releases the CPU to fetch from the freshly loaded image.
- Holds the CPU in upgrade mode while loading and reports completion or error.

Parameters:
ADDR_W, 14, word-address width of the program ROM (depth 2^ADDR_W words).
TIMEOUT_CYC, 2300000, maximum idle clk cycles between bytes once a load is in progress (100 ms at 23 MHz).

Ports:
clk  input  1  system clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset.
start  input  1  single-cycle pulse (debounced button) that arms a load.
rx_valid  input  1  single-cycle strobe: rx_byte holds a received byte.
rx_byte  input  8  received UART byte.
upg_rst_o  output  1  high = loader inactive, CPU runs from ROM; low = upgrade in progress.
upg_wen_o  output  1  one-cycle ROM write strobe.
upg_adr_o  output  ADDR_W  ROM word address for the write.
upg_dat_o  output  32  ROM write data.
upg_done_o  output  1  load completed successfully; sticky until next start or reset.
upg_err_o  output  1  load aborted (timeout or oversize); sticky until next start or reset.
busy_o  output  1  high in HDR0, HDR1 and DATA.

Behaviour:
- Interface: one clock, clk; reset rstn is synchronous and active-low.
- Reset (rstn=0 at a clk edge): state=IDLE.
  - upg_rst_o=1; upg_wen_o=0; upg_adr_o=0; upg_dat_o=0; upg_done_o=0; upg_err_o=0; busy_o=0.
  - Word counter, byte index and timeout counter are cleared.
  - Reset mid-load aborts immediately. Words already written stay in ROM.
- Host frame:
  - 2 header bytes: word count N, 16-bit, low byte first.
  - Then 4*N data bytes: each word is sent LSB first.
- States:
  - IDLE: upg_rst_o=1. start -> HDR0.
  - HDR0: upg_rst_o=0, busy_o=1. Waits indefinitely; timeout disabled. rx_valid latches N[7:0] -> HDR1.
  - HDR1: rx_valid latches N[15:8].
    - N=0 -> DONE, no writes.
    - N > 2^ADDR_W -> ERR.
    - Otherwise -> DATA; word index=0, byte index=0.
  - DATA: each rx_valid shifts the byte into lane byte_idx (0..3).
    - On byte_idx=3: on the next cycle, upg_wen_o=1 for exactly one cycle, with upg_adr_o=word index and upg_dat_o=assembled word.
    - Word index then increments and byte_idx wraps to 0.
    - After the write of word N-1 -> DONE on the following cycle.
  - DONE: upg_done_o=1, upg_rst_o=0 (done|rst selects CPU mode). start -> HDR0 and clears upg_done_o.
  - ERR: upg_err_o=1, upg_rst_o=0 (CPU stays held). start -> HDR0 and clears upg_err_o.
- Timeout (HDR1 and DATA only):
  - Counter clears on every accepted byte and on entry to HDR1.
  - Reaching TIMEOUT_CYC-1 with no rx_valid -> ERR.
  - rx_valid in the same cycle as expiry: the byte is accepted and no error is raised.
- Ignored inputs:
  - rx_valid in IDLE, DONE and ERR.
  - start in HDR0, HDR1 and DATA.
- Simultaneous start and rx_valid in IDLE/DONE/ERR: the byte is discarded; the transition to HDR0 still occurs.
- upg_adr_o and upg_dat_o hold their last values when upg_wen_o=0.
- Widths and addressing:
  - Word index is ADDR_W+1 bits internally, so N=2^ADDR_W is legal.
  - Last write address is 2^ADDR_W-1; no wrap-around.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.

Test Plan:
- Reset then idle: outputs match the reset values; rx_valid with 0xAA and no start -> no upg_wen_o, state IDLE.
- start, then bytes 02 00 | 78 56 34 12 | EF BE AD DE -> writes adr0=0x12345678 then adr1=0xDEADBEEF; each upg_wen_o is one cycle wide, one cycle after the 4th byte; upg_done_o=1 the cycle after the second write; upg_rst_o stays 0.
- start, then header 00 00 -> DONE with zero upg_wen_o pulses; start again -> upg_done_o clears, state HDR0.
- start, then header 01 40 (N=16385, ADDR_W=14) -> ERR, upg_err_o=1, no writes.
- start, header 01 00, then 2 data bytes and silence for TIMEOUT_CYC cycles (bench uses TIMEOUT_CYC=16) -> ERR, no write.
  - Repeat with the 3rd byte arriving exactly on the expiry cycle -> accepted, no error.
- rstn=0 for one cycle mid-DATA, after 1 of 3 words written -> next cycle all outputs at reset values; a full reload then succeeds starting from adr0.
